// File: rtl/dr_pkg.sv
// Shared definitions for dual-rail bus arbitration: rail encodings, sequencer
// states and a counter-width helper.
package dr_pkg;

  localparam logic [1:0] DR_0 = 2'b00;
  localparam logic [1:0] DR_1 = 2'b01;
  localparam logic [1:0] DR_Z = 2'b10;
  localparam logic [1:0] DR_X = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    TURN
  } dr_state_e;

  // Width of a counter/index holding 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping around, returned as one-hot plus index.
module rr_pick
  import dr_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = cnt_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  logic [PW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = PW'((32'(ptr_i) + k) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/dr_bus_arbiter.sv
// Round-robin sequencer for a shared dual-rail tri-state net: grants one driver,
// inserts enable-free turnaround cycles and watches the resolved bus for faults.
module dr_bus_arbiter
  import dr_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned TURN_CYC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [N-1:0] en_b1,
  output logic [N-1:0] en_b0,
  input  logic         bus_b1,
  input  logic         bus_b0,
  output logic         busy,
  output logic         err_cont,
  output logic         err_float,
  output logic         err_leak,
  input  logic         err_clr
);

  localparam int unsigned PW = cnt_w(N);
  localparam int unsigned HW = cnt_w(MAX_HOLD);
  localparam int unsigned TW = cnt_w(TURN_CYC);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("dr_bus_arbiter: N must be in 2..16");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("dr_bus_arbiter: MAX_HOLD must be >= 2");
  end
  if (TURN_CYC < 1) begin : g_bad_turn
    $error("dr_bus_arbiter: TURN_CYC must be >= 1");
  end

  dr_state_e           state_q, state_d;
  logic [N-1:0]        gnt_q, gnt_d;
  logic [PW-1:0]       gidx_q, gidx_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [TW-1:0]       turn_q, turn_d;
  logic [N-1:0][1:0]   en_q, en_d;
  logic                busy_q, busy_d;
  logic                err_cont_q, err_cont_d;
  logic                err_float_q, err_float_d;
  logic                err_leak_q, err_leak_d;

  logic [1:0]          bus;
  logic                cont_set, float_set, leak_set;
  logic [N-1:0]        pick_gnt;
  logic [PW-1:0]       pick_idx;
  logic                pick_valid;
  logic [PW-1:0]       ptr_next;

  assign bus = {bus_b1, bus_b0};

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Pointer moves past the current owner regardless of why it released.
  assign ptr_next = (gidx_q == PW'(N - 1)) ? '0 : gidx_q + PW'(1);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    turn_d    = turn_q;
    cont_set  = 1'b0;
    float_set = 1'b0;
    leak_set  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = DRIVE;
          gnt_d   = pick_gnt;
          gidx_d  = pick_idx;
          hold_d  = '0;
        end
      end
      DRIVE: begin
        hold_d = hold_q + HW'(1);
        // First drive cycle is settling time; the net is not judged yet.
        if (hold_q != '0) begin
          cont_set  = (bus == DR_X);
          float_set = (bus == DR_Z);
        end
        if (!req[gidx_q] || hold_q == HW'(MAX_HOLD - 1)) begin
          state_d = TURN;
          gnt_d   = '0;
          ptr_d   = ptr_next;
          hold_d  = '0;
          turn_d  = '0;
        end
      end
      TURN: begin
        turn_d = turn_q + TW'(1);
        if (turn_q == TW'(TURN_CYC - 1)) begin
          leak_set = (bus != DR_Z);
          state_d  = IDLE;
          turn_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      en_d[i] = gnt_d[i] ? DR_1 : DR_0;
    end
    busy_d      = (state_d != IDLE);
    // A fault detected in the same cycle as a clear still latches.
    err_cont_d  = (err_cont_q  & ~err_clr) | cont_set;
    err_float_d = (err_float_q & ~err_clr) | float_set;
    err_leak_d  = (err_leak_q  & ~err_clr) | leak_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gidx_q      <= '0;
      ptr_q       <= '0;
      hold_q      <= '0;
      turn_q      <= '0;
      en_q        <= '0;
      busy_q      <= 1'b0;
      err_cont_q  <= 1'b0;
      err_float_q <= 1'b0;
      err_leak_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      turn_q      <= turn_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      err_cont_q  <= err_cont_d;
      err_float_q <= err_float_d;
      err_leak_q  <= err_leak_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      en_b1[i] = en_q[i][1];
      en_b0[i] = en_q[i][0];
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign err_cont  = err_cont_q;
  assign err_float = err_float_q;
  assign err_leak  = err_leak_q;

endmodule

// File: doc/dr_bus_arbiter.md
Name: dr_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared dual-rail-encoded tri-state net. The net is driven through enable-gated buffers of the en1/en2b style.
- Grants one requester at a time and drives that requester's buffer enable in dual-rail form.
- Inserts turnaround cycles in which no buffer is enabled, so handover never overlaps.
- Monitors the resolved bus value and flags contention (X), floating (Z while driven) and leakage (driven while released).

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum DRIVE cycles per grant (>=2).
- TURN_CYC, 1, turnaround cycles with all enables off (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset, sampled on rising clk.
- req  in  N  per-requester bus request, level.
- gnt  out  N  one-hot grant; held through DRIVE.
- en_b1  out  N  enable, dual-rail bit 1.
- en_b0  out  N  enable, dual-rail bit 0.
- bus_b1  in  1  resolved shared net, dual-rail bit 1.
- bus_b0  in  1  resolved shared net, dual-rail bit 0.
- busy  out  1  state != IDLE.
- err_cont  out  1  sticky: X seen during DRIVE.
- err_float  out  1  sticky: Z seen during DRIVE.
- err_leak  out  1  sticky: non-Z seen at end of TURN.
- err_clr  in  1  clears all sticky errors.

Behaviour:
- Dual-rail encoding {b1,b0}: 00=0, 01=1, 10=Z, 11=X.
- Enable outputs only ever take 00 (off) or 01 (on). The arbiter never emits X or Z on an enable.
- Reset: state=IDLE; gnt=0; all en=00; busy=0; all err=0; hold_cnt=0; turn_cnt=0; rr_ptr=0.
  - Reset asserted mid-DRIVE: all enables are 00 on the next edge. No TURN is inserted.
- All outputs are registered.
- IDLE:
  - If req!=0, select the first set bit searching upward from rr_ptr, with wrap-around.
  - Next edge: state=DRIVE, gnt[g]=1, en[g]=01, hold_cnt=0.
  - req->gnt latency is 1 cycle. A req pulse that drops before the arbitration edge is not granted.
- DRIVE:
  - hold_cnt increments each cycle.
  - Exit to TURN on the edge where req[g]==0 or hold_cnt==MAX_HOLD-1.
  - On exit: gnt=0, all en=00, rr_ptr=(g+1) mod N, turn_cnt=0.
- Bus check in DRIVE, skipping the first cycle (settling):
  - bus==11 sets err_cont.
  - bus==10 sets err_float.
- TURN:
  - All en=00; turn_cnt increments.
  - On the cycle turn_cnt==TURN_CYC-1: if bus!=10, set err_leak. Next edge: state=IDLE.
  - Requests arriving during TURN are evaluated in IDLE. Minimum grant-to-grant spacing is 1+TURN_CYC+1 cycles.
- Fairness: a requester holding req continuously is preempted after MAX_HOLD cycles. It is re-granted only after every other asserted requester has been served once.
- Simultaneous events:
  - err_clr together with a new error condition: the set wins.
  - req[g] drop in the same cycle as hold_cnt expiry: a single exit to TURN.
- Invariant: popcount(gnt)<=1 and popcount(en==01)<=1 at all times. gnt[i]==1 iff en[i]==01.

Decomposition:
- Shared package dr_pkg holds:
  - dual-rail constants DR_0=2'b00, DR_1=2'b01, DR_Z=2'b10, DR_X=2'b11;
  - the state enum {IDLE, DRIVE, TURN}.
- One sub-module, rr_pick: combinational round-robin priority picker (req, rr_ptr -> one-hot, valid). It is reused by other arbiters in the tree.

Test Plan:
- Single requester (N=4): req=0001 held 3 cycles then dropped, bus=01 -> gnt=0001 one cycle after req; en[0]=01 for 3 DRIVE cycles; TURN for 1 cycle; busy=0 again; no errors.
- Round-robin: req=1111 held, bus=01 -> grants in order 0001, 0010, 0100, 1000, 0001; each lasts 8 cycles; each pair is separated by 1 TURN cycle plus 1 IDLE cycle.
- Contention: during DRIVE cycle 3, force bus=11 -> err_cont=1 and stays 1 until err_clr. Pulse err_clr with no new fault -> err_cont=0.
- Float and leak:
  - bus=10 during DRIVE cycle 2 -> err_float=1.
  - bus=00 during the TURN cycle -> err_leak=1.
  - err_clr asserted in the same cycle as a new fault -> the error remains 1.
- Reset mid-grant: rst=1 during DRIVE of requester 2 -> next edge gnt=0, all en=00, errors cleared. After reset, req=0110 -> gnt=0010 (pointer restarted at 0).
- Short request: req[3] pulsed for 1 cycle while in TURN -> never granted; gnt stays 0.
